// File: rtl/toy_pkg.sv
// Shared TOY types, ASCII constants and hex helpers for the word-to-ASCII formatter.
// Build option UART_HEX_CRLF_EN selects a CR+LF terminator; without it lines end in LF only.
package toy_pkg;

   typedef logic [15:0] word_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

`ifdef UART_HEX_CRLF_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIGIT = 2'd1,
      ST_CR    = 2'd2,
      ST_LF    = 2'd3
   } hex_tx_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIGIT = 2'd1,
      ST_LF    = 2'd3
   } hex_tx_state_e;
`endif

   function automatic logic [7:0] hex_ascii(input logic [3:0] value);
      logic [7:0] code;
      if (value < 4'd10) begin
         code = ASCII_0 + {4'h0, value};
      end else begin
         code = ASCII_A + ({4'h0, value} - 8'd10);
      end
      return code;
   endfunction

   function automatic logic [3:0] nibble_sel(input word_t w, input logic [1:0] idx);
      return w[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/uart_hex_tx_if.sv
// Word-in / byte-out handshake bundle for uart_hex_tx; slave is the formatter side.
interface uart_hex_tx_if;
   import toy_pkg::*;

   logic       word_val_i;
   word_t      word_i;
   logic       word_rdy_o;
   logic       out_val_o;
   logic [7:0] out_data_o;
   logic       out_rdy_i;
   logic       busy_o;

   modport master (
      output word_val_i, word_i, out_rdy_i,
      input  word_rdy_o, out_val_o, out_data_o, busy_o
   );

   modport slave (
      input  word_val_i, word_i, out_rdy_i,
      output word_rdy_o, out_val_o, out_data_o, busy_o
   );

endinterface

// File: rtl/word_fifo.sv
// Small synchronous FIFO for TOY words; full/empty come straight from registered occupancy.
module word_fifo
   import toy_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = $bits(word_t)
)
(
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1'b1);
   localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // A push while full is dropped even when a pop frees a slot in the same cycle.
   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rd_data   = mem_r[rd_ptr_r];

   // Storage array write port.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_hex_tx.sv
// Formats buffered 16-bit TOY words as four uppercase hex digits plus a line terminator.
// UART_HEX_CRLF_EN defined: CR+LF terminator; undefined: LF only.
module uart_hex_tx
   import toy_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic         clk_i,
   input  logic         srst_i,
   uart_hex_tx_if.slave bus
);

   hex_tx_state_e state_r;
   hex_tx_state_e state_nxt_s;
   word_t         word_r;
   word_t         word_nxt_s;
   word_t         fifo_head_s;
   logic [1:0]    idx_r;
   logic [1:0]    idx_nxt_s;
   logic          out_val_r;
   logic          out_val_nxt_s;
   logic [7:0]    out_data_r;
   logic [7:0]    out_data_nxt_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          pop_s;

   word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(word_t))
   ) u_fifo (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .push    (bus.word_val_i),
      .wr_data (bus.word_i),
      .pop     (pop_s),
      .rd_data (fifo_head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Next state and next output byte; each byte is loaded together with the state that owns it.
   always_comb begin
      state_nxt_s    = state_r;
      word_nxt_s     = word_r;
      idx_nxt_s      = idx_r;
      out_val_nxt_s  = out_val_r;
      out_data_nxt_s = out_data_r;
      pop_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s          = 1'b1;
               word_nxt_s     = fifo_head_s;
               idx_nxt_s      = 2'd3;
               state_nxt_s    = ST_DIGIT;
               out_val_nxt_s  = 1'b1;
               out_data_nxt_s = hex_ascii(nibble_sel(fifo_head_s, 2'd3));
            end else begin
               out_val_nxt_s  = 1'b0;
            end
         end
         ST_DIGIT: begin
            if (bus.out_rdy_i) begin
               if (idx_r == 2'd0) begin
`ifdef UART_HEX_CRLF_EN
                  state_nxt_s    = ST_CR;
                  out_data_nxt_s = ASCII_CR;
`else
                  state_nxt_s    = ST_LF;
                  out_data_nxt_s = ASCII_LF;
`endif
               end else begin
                  idx_nxt_s      = idx_r - 2'd1;
                  out_data_nxt_s = hex_ascii(nibble_sel(word_r, idx_r - 2'd1));
               end
            end else begin
               out_val_nxt_s = 1'b1;
            end
         end
`ifdef UART_HEX_CRLF_EN
         ST_CR: begin
            if (bus.out_rdy_i) begin
               state_nxt_s    = ST_LF;
               out_data_nxt_s = ASCII_LF;
            end else begin
               out_val_nxt_s  = 1'b1;
            end
         end
`endif
         ST_LF: begin
            if (bus.out_rdy_i) begin
               state_nxt_s   = ST_IDLE;
               out_val_nxt_s = 1'b0;
            end else begin
               out_val_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            out_val_nxt_s = 1'b0;
         end
      endcase
   end

   // State, word, digit index and output byte registers; reset abandons any partial line.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_r    <= ST_IDLE;
         word_r     <= 16'h0000;
         idx_r      <= 2'd0;
         out_val_r  <= 1'b0;
         out_data_r <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         word_r     <= word_nxt_s;
         idx_r      <= idx_nxt_s;
         out_val_r  <= out_val_nxt_s;
         out_data_r <= out_data_nxt_s;
      end
   end

   assign bus.word_rdy_o = ~fifo_full_s;
   assign bus.out_val_o  = out_val_r;
   assign bus.out_data_o = out_data_r;
   assign bus.busy_o     = ~fifo_empty_s | (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_hex_tx.sv
// Self-checking bench for uart_hex_tx: directed scenarios plus random traffic against a byte-queue model.
module tb_uart_hex_tx;
   import toy_pkg::*;

   logic clk = 1'b0;
   logic srst;

   uart_hex_tx_if bus();

   uart_hex_tx #(.DEPTH(4)) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

`ifdef UART_HEX_CRLF_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif

   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         push_cyc = 0;
   int         n_pushed = 0;
   int         n0;
   logic [7:0] exp_q[$];
   int         acc_q[$];

   function automatic logic [7:0] hex_char(input int v);
      if (v < 10) return 8'(48 + v);
      else return 8'(55 + v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected line for a word: four hex digits, most significant first, then the terminator.
   task automatic model_push(input logic [15:0] w);
      for (int k = 3; k >= 0; k--) begin
         exp_q.push_back(hex_char(int'((w >> (4 * k)) & 16'h000F)));
      end
`ifdef UART_HEX_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
      n_pushed++;
   endtask

   // One clock: record handshakes that complete at the coming edge, then check hold stability.
   task automatic step();
      logic       hold_v;
      logic [7:0] hold_d;
      hold_v = bus.out_val_o && !bus.out_rdy_i && !srst;
      hold_d = bus.out_data_o;
      if (srst) begin
         exp_q.delete();
      end else begin
         if (bus.word_val_i && bus.word_rdy_o) begin
            model_push(bus.word_i);
            push_cyc = cyc;
         end
         if (bus.out_val_o && bus.out_rdy_i) begin
            if (exp_q.size() > 0) begin
               chk("byte", 32'(bus.out_data_o), 32'(exp_q.pop_front()));
            end else begin
               n_chk++;
               n_err++;
               $error("FAIL unexpected_byte observed=0x%0h expected=none", bus.out_data_o);
            end
            acc_q.push_back(cyc);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (hold_v) begin
         chk("hold_val", 32'(bus.out_val_o), 32'd1);
         chk("hold_data", 32'(bus.out_data_o), 32'(hold_d));
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      bus.word_val_i = 1'b1;
      bus.word_i     = w;
      step();
      bus.word_val_i = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      srst           = 1'b1;
      bus.word_val_i = 1'b0;
      bus.word_i     = 16'h0000;
      bus.out_rdy_i  = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("rst_out_val", 32'(bus.out_val_o), 32'd0);
      chk("rst_out_data", 32'(bus.out_data_o), 32'h00);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_word_rdy", 32'(bus.word_rdy_o), 32'd1);
      srst = 1'b0;
      step();

      // Single word, free-flowing output: 2-cycle latency, one byte per cycle.
      bus.out_rdy_i = 1'b1;
      acc_q.delete();
      push_word(16'h1A2F);
      drain("t1_drain", 40);
      chk("t1_latency", 32'(acc_q[0]), 32'(push_cyc + 2));
      chk("t1_count", 32'(acc_q.size()), 32'(NB));
      for (int i = 1; i < acc_q.size(); i++) begin
         chk("t1_back2back", 32'(acc_q[i]), 32'(acc_q[i-1] + 1));
      end
      step();

      // Two words back to back: next line starts one idle cycle after the terminator.
      acc_q.delete();
      bus.word_val_i = 1'b1;
      bus.word_i     = 16'h5A5A;
      step();
      bus.word_i     = 16'hC3E1;
      step();
      bus.word_val_i = 1'b0;
      drain("tput_drain", 60);
      chk("tput_count", 32'(acc_q.size()), 32'(2 * NB));
      chk("tput_period", 32'(acc_q[NB] - acc_q[0]), 32'(NB + 1));

      // Backpressure after the second byte of 16'h1234.
      push_word(16'h1234);
      for (int i = 0; i < 10 && exp_q.size() > NB - 1; i++) step();
      chk("t2_second_byte", 32'(bus.out_data_o), 32'h32);
      bus.out_rdy_i = 1'b0;
      repeat (10) step();
      chk("t2_hold_val", 32'(bus.out_val_o), 32'd1);
      chk("t2_hold_data", 32'(bus.out_data_o), 32'h32);
      bus.out_rdy_i = 1'b1;
      drain("t2_drain", 40);
      step();

      // Six words offered with output stalled: one in the FSM plus four buffered.
      bus.out_rdy_i  = 1'b0;
      n0             = n_pushed;
      bus.word_val_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.word_i = 16'($urandom);
         step();
      end
      bus.word_val_i = 1'b0;
      chk("t3_accepted", 32'(n_pushed - n0), 32'd5);
      chk("t3_word_rdy_low", 32'(bus.word_rdy_o), 32'd0);
      chk("t3_busy", 32'(bus.busy_o), 32'd1);
      bus.out_rdy_i = 1'b1;
      drain("t3_drain", 100);
      step();

      // All-zero and all-ones words; busy drops right after the final LF is taken.
      bus.word_val_i = 1'b1;
      bus.word_i     = 16'h0000;
      step();
      bus.word_i     = 16'hFFFF;
      step();
      bus.word_val_i = 1'b0;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
         if (exp_q.size() == 1) chk("t4_busy_before", 32'(bus.busy_o), 32'd1);
         step();
      end
      chk("t4_drain", 32'(exp_q.size()), 32'd0);
      chk("t4_busy_after", 32'(bus.busy_o), 32'd0);

      // Reset mid-line with two words queued; a push during reset is dropped.
      bus.out_rdy_i  = 1'b0;
      bus.word_val_i = 1'b1;
      bus.word_i     = 16'hABCD;
      step();
      bus.word_i     = 16'($urandom);
      step();
      bus.word_i     = 16'($urandom);
      step();
      bus.word_val_i = 1'b0;
      bus.out_rdy_i  = 1'b1;
      step();
      step();
      bus.out_rdy_i  = 1'b0;
      srst           = 1'b1;
      bus.word_val_i = 1'b1;
      bus.word_i     = 16'h7777;
      step();
      srst           = 1'b0;
      bus.word_val_i = 1'b0;
      chk("t5_out_val", 32'(bus.out_val_o), 32'd0);
      chk("t5_busy", 32'(bus.busy_o), 32'd0);
      chk("t5_word_rdy", 32'(bus.word_rdy_o), 32'd1);
      chk("t5_out_data", 32'(bus.out_data_o), 32'h00);
      bus.out_rdy_i = 1'b1;
      acc_q.delete();
      push_word(16'h0042);
      drain("t5_drain", 40);
      chk("t5_latency", 32'(acc_q[0]), 32'(push_cyc + 2));

      // Word containing both digit classes, checked against the model terminator.
      push_word(16'h00F0);
      drain("t6_drain", 40);

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         bus.word_val_i = ($urandom_range(0, 2) == 0);
         bus.word_i     = 16'($urandom);
         bus.out_rdy_i  = 1'($urandom_range(0, 1));
         step();
      end
      bus.word_val_i = 1'b0;
      bus.out_rdy_i  = 1'b1;
      drain("rand_drain", 400);
      step();
      chk("final_busy", 32'(bus.busy_o), 32'd0);
      chk("final_out_val", 32'(bus.out_val_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
